// File: rtl/uart_frame_sender_pkg.sv
// Shared types and constants for the UART word-to-frame sender.
// A frame is SOF, four payload bytes (LSB first) and an XOR checksum
// over the payload bytes only.
package uart_frame_sender_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SEND,
      S_WAIT
   } state_t;

   localparam int         FRAME_BYTES = 6;
   localparam logic [2:0] SOF_IDX     = 3'd0;
   localparam logic [2:0] CSUM_IDX    = 3'(FRAME_BYTES - 1);
   localparam logic [7:0] DEFAULT_SOF = 8'hA5;

   // Byte at position idx of the frame carrying word; idx 5 is the checksum.
   function automatic logic [7:0] frame_byte(
      input logic [2:0]  idx,
      input logic [31:0] word,
      input logic [7:0]  csum,
      input logic [7:0]  sof
   );
      logic [7:0] b;
      b = csum;
      case (idx)
         SOF_IDX: b = sof;
         3'd1:    b = word[7:0];
         3'd2:    b = word[15:8];
         3'd3:    b = word[23:16];
         3'd4:    b = word[31:24];
         default: b = csum;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data.
// A pop presents the head entry on data_o in the following cycle.
// Pushes are refused when full, even if a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int             AW      = $clog2(DEPTH);
   localparam int             CW      = AW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             push_ok;
   logic             pop_ok;

   assign full_o  = (count_q == DEPTH_C);
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = rd_data_q;
   assign count_o = count_q;

   // Occupancy next-state: simultaneous push and pop leaves it unchanged.
   always_comb begin
      // NOTE: every variable assigned here gets a default first so no latch is inferred.
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointers, occupancy and read register; pointers wrap modulo DEPTH.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= '0;
      end else begin
         count_q <= count_d;
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q  <= rd_ptr_q + 1'b1;
            rd_data_q <= mem_q[rd_ptr_q];
         end
      end
   end

   // Storage array write port.
   always_ff @(posedge clk_i) begin
      // NOTE: storage is not reset; pointers and count alone define which entries are valid.
      if (push_ok) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/uart_frame_sender.sv
// Word-to-frame sender driving a byte-level UART transmitter.
// Each queued 32-bit word leaves as SOF, 4 payload bytes LSB first, XOR checksum.
// Optional statistics (frames_sent_o, overflow_o) with UART_FRAME_SENDER_STATS_EN.
module uart_frame_sender
   import uart_frame_sender_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter logic [7:0] SOF_BYTE   = DEFAULT_SOF
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [31:0]                   word_i,
   input  logic                          word_valid_i,
   output logic                          word_ready_o,
   output logic [7:0]                    tx_data_o,
   output logic                          tx_start_o,
   input  logic                          tx_busy_i,
   input  logic                          tx_done_i,
   output logic                          busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef UART_FRAME_SENDER_STATS_EN
   ,
   output logic [15:0]                   frames_sent_o,
   output logic                          overflow_o
`endif
);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] word_q;
   logic [31:0] word_d;
   logic [7:0]  csum_q;
   logic [7:0]  csum_d;
   logic [2:0]  byte_idx_q;
   logic [2:0]  byte_idx_d;
   logic [7:0]  tx_data_q;
   logic [7:0]  tx_data_d;
   logic [7:0]  next_byte;

   logic        fifo_push;
   logic        fifo_pop;
   logic [31:0] fifo_rd_data;
   logic        fifo_full;
   logic        fifo_empty;

   assign word_ready_o = !fifo_full;
   assign fifo_push    = word_valid_i && word_ready_o;
   assign tx_data_o    = tx_data_q;
   assign busy_o       = (state_q != S_IDLE) || !fifo_empty;

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (word_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rd_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_o)
   );

   // Frame sequencing: next state, byte staging, checksum and start pulse.
   // The outgoing byte is registered on entry to S_SEND so it is stable
   // when the start pulse fires and holds until the next byte is staged.
   always_comb begin
      state_d    = state_q;
      word_d     = word_q;
      csum_d     = csum_q;
      byte_idx_d = byte_idx_q;
      tx_data_d  = tx_data_q;
      next_byte  = 8'h00;
      fifo_pop   = 1'b0;
      tx_start_o = 1'b0;

      case (state_q)
         S_IDLE: begin
            // Pop now; the registered FIFO read lands during S_LOAD.
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               state_d  = S_LOAD;
            end
         end

         S_LOAD: begin
            word_d     = fifo_rd_data;
            csum_d     = 8'h00;
            byte_idx_d = SOF_IDX;
            tx_data_d  = SOF_BYTE;
            state_d    = S_SEND;
         end

         S_SEND: begin
            if (!tx_busy_i) begin
               tx_start_o = 1'b1;
               state_d    = S_WAIT;
            end
         end

         S_WAIT: begin
            if (tx_done_i) begin
               if (byte_idx_q == CSUM_IDX) begin
                  state_d = S_IDLE;
               end else begin
                  byte_idx_d = byte_idx_q + 3'd1;
                  next_byte  = frame_byte(byte_idx_d, word_q, csum_q, SOF_BYTE);
                  tx_data_d  = next_byte;
                  // Only payload bytes feed the checksum.
                  if (byte_idx_d != CSUM_IDX) begin
                     csum_d = csum_q ^ next_byte;
                  end
                  state_d = S_SEND;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // Frame state registers with synchronous reset; reset aborts any frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         word_q     <= '0;
         csum_q     <= '0;
         byte_idx_q <= '0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         word_q     <= word_d;
         csum_q     <= csum_d;
         byte_idx_q <= byte_idx_d;
         tx_data_q  <= tx_data_d;
      end
   end

`ifdef UART_FRAME_SENDER_STATS_EN
   logic [15:0] frames_sent_q;
   logic        overflow_q;
   logic        frame_done;

   assign frame_done    = (state_q == S_WAIT) && tx_done_i && (byte_idx_q == CSUM_IDX);
   assign frames_sent_o = frames_sent_q;
   assign overflow_o    = overflow_q;

   // Completed-frame counter (wraps) and sticky refused-push flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frames_sent_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         if (frame_done) begin
            frames_sent_q <= frames_sent_q + 16'd1;
         end
         if (word_valid_i && !word_ready_o) begin
            overflow_q <= 1'b1;
         end
      end
   end
`endif

endmodule
